tag_responder_unit: RTL

Parametrised successor to the CAPP tag register: holds one tag bit per CAM word and applies a per-cycle tag operation: set all, clear all, match-clear from mismatch lines, select-first, clear-first. It adds a responder-enumeration mode that streams the indices of all tagged words, lowest first, over a valid/ready handshake, clearing each tag as its index is taken. It sits between the CAM cell array (mismatch lines in) and the controller or output bus (tags, some/none, responder indices out).

---
 rtl/tag_pkg.sv | 22 ++
 rtl/tag_priority_encoder.sv | 31 +++
 rtl/tag_responder_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/tag_pkg.sv
// Shared types for the tag responder unit.
//   tag_op_e    : 3-bit tag operation codes accepted on cmd_op.
//   tag_state_e : responder FSM states (idle / enumerating).
package tag_pkg;

  typedef enum logic [2:0] {
    OpNop         = 3'd0,
    OpSetAll      = 3'd1,
    OpClearAll    = 3'd2,
    OpMatch       = 3'd3,
    OpSelectFirst = 3'd4,
    OpClearFirst  = 3'd5,
    OpEnumerate   = 3'd6,
    OpReserved    = 3'd7
  } tag_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StEnum = 1'b1
  } tag_state_e;

endpackage

// File: rtl/tag_priority_encoder.sv
// Lowest-index priority encoder over the tag vector.
//   tags         in  N_WORDS : tag bits
//   any          out 1       : at least one tag set
//   first_idx    out IDX_W   : index of the lowest set tag (0 when none)
//   first_onehot out N_WORDS : one-hot mask of the lowest set tag (0 when none)
module tag_priority_encoder
  import tag_pkg::*;
#(
  parameter int unsigned N_WORDS = 100,
  localparam int unsigned IDX_W = $clog2(N_WORDS)
) (
  input  logic [N_WORDS-1:0] tags,
  output logic               any,
  output logic [IDX_W-1:0]   first_idx,
  output logic [N_WORDS-1:0] first_onehot
);

  assign any = |tags;

  // Two's-complement trick isolates the lowest set bit.
  assign first_onehot = tags & (-tags);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    first_idx = '0;
    for (int i = int'(N_WORDS) - 1; i >= 0; i--) begin
      if (tags[i]) first_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tag_responder_unit.sv
// Tag register for a CAM array with per-cycle tag operations and a responder
// enumeration mode that streams tagged word indices lowest-first.
//   CLK, RST_N      : clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready : command handshake; ready only while idle
//   cmd_op          : tag_op_e operation code
//   mismatch_lines  : per-word mismatch, used by MATCH only
//   tag_wires       : registered tag bits
//   some_none       : any tag set
//   tag_count       : number of set tags
//   resp_valid/ready: responder index handshake (enumeration only)
//   resp_index      : lowest set tag index while resp_valid, else 0
//   resp_last       : current index is the final responder
//   enum_done       : one-cycle pulse on the first idle cycle after enumeration
module tag_responder_unit
  import tag_pkg::*;
#(
  parameter int unsigned N_WORDS = 100,
  localparam int unsigned IDX_W = $clog2(N_WORDS)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  output logic               cmd_ready,
  input  logic [N_WORDS-1:0] mismatch_lines,
  output logic [N_WORDS-1:0] tag_wires,
  output logic               some_none,
  output logic [IDX_W:0]     tag_count,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDX_W-1:0]   resp_index,
  output logic               resp_last,
  output logic               enum_done
);

  tag_state_e         state_q, state_d;
  logic [N_WORDS-1:0] tag_q, tag_d;
  logic               enum_done_q, enum_done_d;

  logic               first_any;
  logic [IDX_W-1:0]   first_idx;
  logic [N_WORDS-1:0] first_onehot;
  logic [IDX_W:0]     count;

  // Single encoder shared by SELECT_FIRST, CLEAR_FIRST and enumeration.
  tag_priority_encoder #(
    .N_WORDS (N_WORDS)
  ) u_prio (
    .tags         (tag_q),
    .any          (first_any),
    .first_idx    (first_idx),
    .first_onehot (first_onehot)
  );

  // Popcount; synthesis balances the accumulation into an adder tree.
  always_comb begin
    count = '0;
    for (int i = 0; i < int'(N_WORDS); i++) begin
      count = count + (IDX_W + 1)'(tag_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    enum_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (tag_op_e'(cmd_op))
            OpSetAll:      tag_d = '1;
            OpClearAll:    tag_d = '0;
            OpMatch:       tag_d = tag_q & ~mismatch_lines;
            OpSelectFirst: tag_d = first_onehot;
            OpClearFirst:  tag_d = tag_q & ~first_onehot;
            OpEnumerate:   state_d = StEnum;
            default:       tag_d = tag_q;
          endcase
        end
      end
      StEnum: begin
        if (!first_any) begin
          // Entered with nothing tagged: leave immediately.
          state_d     = StIdle;
          enum_done_d = 1'b1;
        end else if (resp_ready) begin
          tag_d = tag_q & ~first_onehot;
          if (count == (IDX_W + 1)'(1)) begin
            state_d     = StIdle;
            enum_done_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      enum_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      enum_done_q <= enum_done_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign tag_wires  = tag_q;
  assign some_none  = first_any;
  assign tag_count  = count;
  assign resp_valid = (state_q == StEnum) && first_any;
  assign resp_index = resp_valid ? first_idx : '0;
  assign resp_last  = resp_valid && (count == (IDX_W + 1)'(1));
  assign enum_done  = enum_done_q;

endmodule
